// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its pipelined wrapper.
package alu_ctrl_pkg;

    // ALUop codes from the instruction-decode stage
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_SLL   = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b010;
    localparam logic [2:0] OP_SRA   = 3'b011;
    localparam logic [2:0] OP_COMPI = 3'b100;
    localparam logic [2:0] OP_RTYPE = 3'b111;

    // R-type funct codes; anything outside 1..8 is undefined
    localparam logic [5:0] F_ADD   = 6'd1;
    localparam logic [5:0] F_COMP  = 6'd2;
    localparam logic [5:0] F_AND   = 6'd3;
    localparam logic [5:0] F_XOR   = 6'd4;
    localparam logic [5:0] F_DIFF  = 6'd5;
    localparam logic [5:0] F_SHLV  = 6'd6;
    localparam logic [5:0] F_SHRV  = 6'd7;
    localparam logic [5:0] F_SHRAV = 6'd8;

    // ALU control words (5 significant bits; wider words are zero-extended)
    localparam logic [4:0] CTRL_ADD  = 5'b00000;
    localparam logic [4:0] CTRL_AND  = 5'b00001;
    localparam logic [4:0] CTRL_XOR  = 5'b00010;
    localparam logic [4:0] CTRL_SLL  = 5'b00011;
    localparam logic [4:0] CTRL_SRL  = 5'b00111;
    localparam logic [4:0] CTRL_SRA  = 5'b01111;
    localparam logic [4:0] CTRL_COMP = 5'b01100;
    localparam logic [4:0] CTRL_DIFF = 5'b10000;

    // A control word selects the shifter when it is one of the three shift codes
    function automatic logic is_shift(input logic [4:0] c);
        return (c == CTRL_SLL) || (c == CTRL_SRL) || (c == CTRL_SRA);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {ALUop, funct} -> {ctrl, illegal, shift} decoder.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 5
) (
    input  logic [OP_W-1:0]    aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               illegal,
    output logic               shift
);

    logic [4:0] ctrl5;

    // Fixed-function ALUops ignore funct; R-type looks funct up, unknowns flag illegal
    always_comb begin
        ctrl5   = CTRL_ADD;
        illegal = 1'b0;
        case (aluop)
            OP_W'(OP_NONE):  ctrl5 = CTRL_ADD;
            OP_W'(OP_SLL):   ctrl5 = CTRL_SLL;
            OP_W'(OP_SRL):   ctrl5 = CTRL_SRL;
            OP_W'(OP_SRA):   ctrl5 = CTRL_SRA;
            OP_W'(OP_COMPI): ctrl5 = CTRL_COMP;
            OP_W'(OP_RTYPE): begin
                case (funct)
                    FUNCT_W'(F_ADD):   ctrl5 = CTRL_ADD;
                    FUNCT_W'(F_COMP):  ctrl5 = CTRL_COMP;
                    FUNCT_W'(F_AND):   ctrl5 = CTRL_AND;
                    FUNCT_W'(F_XOR):   ctrl5 = CTRL_XOR;
                    FUNCT_W'(F_DIFF):  ctrl5 = CTRL_DIFF;
                    FUNCT_W'(F_SHLV):  ctrl5 = CTRL_SLL;
                    FUNCT_W'(F_SHRV):  ctrl5 = CTRL_SRL;
                    FUNCT_W'(F_SHRAV): ctrl5 = CTRL_SRA;
                    default:           illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ctrl  = CTRL_W'(ctrl5);
    assign shift = is_shift(ctrl5);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder: valid/ready input, DEPTH-entry result FIFO,
// saturating illegal-op counter for debug.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 3,
    parameter int FUNCT_W   = 6,
    parameter int CTRL_W    = 5,
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_aluop,
    input  logic [FUNCT_W-1:0]   in_funct,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic                 out_illegal,
    output logic                 out_shift,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 cnt_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              dec_shift;

    logic [CTRL_W-1:0] ctrl_mem [DEPTH];
    logic [DEPTH-1:0]  ill_mem;
    logic [DEPTH-1:0]  shf_mem;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              ill_push;

    alu_ctrl_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .aluop   (in_aluop),
        .funct   (in_funct),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .shift   (dec_shift)
    );

    // in_ready comes only from registered occupancy, so a full FIFO refuses a
    // push even when the head is popped in the same cycle
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ill_push  = push && dec_illegal;

    // Head outputs are forced to zero while nothing is buffered
    assign out_ctrl    = empty ? '0   : ctrl_mem[rd_ptr];
    assign out_illegal = empty ? 1'b0 : ill_mem[rd_ptr];
    assign out_shift   = empty ? 1'b0 : shf_mem[rd_ptr];

    // Payload storage; contents are only observed through the valid window
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr] <= dec_ctrl;
            ill_mem[wr_ptr]  <= dec_illegal;
            shf_mem[wr_ptr]  <= dec_shift;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy counter tracks full/empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating illegal-op counter; a clear coinciding with an illegal push keeps that event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= ill_push ? ERR_CNT_W'(1) : '0;
        end else if (ill_push && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: handshake, backpressure, illegal ops,
// counter saturation/clear, streaming, and mid-stream reset.
module tb_alu_ctrl_pipe;

    logic       clk;
    logic       rst;

    // main instance, default parameters
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_aluop;
    logic [5:0] in_funct;
    logic [4:0] out_ctrl;
    logic       out_illegal, out_shift, cnt_clr;
    logic [7:0] err_cnt;

    // second instance with a 2-bit counter for saturation checks
    logic       in2_valid, in2_ready, out2_valid, out2_ready;
    logic [2:0] in2_aluop;
    logic [5:0] in2_funct;
    logic [4:0] out2_ctrl;
    logic       out2_illegal, out2_shift, cnt2_clr;
    logic [1:0] err2_cnt;

    int n_chk;
    int n_err;

    alu_ctrl_pipe u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_funct    (in_funct),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal),
        .out_shift   (out_shift),
        .err_cnt     (err_cnt),
        .cnt_clr     (cnt_clr)
    );

    alu_ctrl_pipe #(.ERR_CNT_W(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in2_valid),
        .in_ready    (in2_ready),
        .in_aluop    (in2_aluop),
        .in_funct    (in2_funct),
        .out_valid   (out2_valid),
        .out_ready   (out2_ready),
        .out_ctrl    (out2_ctrl),
        .out_illegal (out2_illegal),
        .out_shift   (out2_shift),
        .err_cnt     (err2_cnt),
        .cnt_clr     (cnt2_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle before driving/sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference decode: {ctrl[4:0], illegal, shift}
    function automatic logic [6:0] model(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'd0: return {5'b00000, 1'b0, 1'b0};
            3'd1: return {5'b00011, 1'b0, 1'b1};
            3'd2: return {5'b00111, 1'b0, 1'b1};
            3'd3: return {5'b01111, 1'b0, 1'b1};
            3'd4: return {5'b01100, 1'b0, 1'b0};
            3'd7: begin
                case (f)
                    6'd1: return {5'b00000, 1'b0, 1'b0};
                    6'd2: return {5'b01100, 1'b0, 1'b0};
                    6'd3: return {5'b00001, 1'b0, 1'b0};
                    6'd4: return {5'b00010, 1'b0, 1'b0};
                    6'd5: return {5'b10000, 1'b0, 1'b0};
                    6'd6: return {5'b00011, 1'b0, 1'b1};
                    6'd7: return {5'b00111, 1'b0, 1'b1};
                    6'd8: return {5'b01111, 1'b0, 1'b1};
                    default: return {5'b00000, 1'b1, 1'b0};
                endcase
            end
            default: return {5'b00000, 1'b1, 1'b0};
        endcase
    endfunction

    logic [6:0] exp_q[$];
    logic [6:0] exp_v;

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b0;
        in_valid = 0; in_aluop = '0; in_funct = '0; out_ready = 0; cnt_clr = 0;
        in2_valid = 0; in2_aluop = '0; in2_funct = '0; out2_ready = 0; cnt2_clr = 0;

        // reset state
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b1;
        step();

        // single op, one-cycle latency, popped next edge
        in_valid = 1; in_aluop = 3'd7; in_funct = 6'd5; out_ready = 1;
        step();
        in_valid = 0;
        check("t1_valid", out_valid, 1);
        check("t1_ctrl", out_ctrl, 5'b10000);
        check("t1_ill_shf", {out_illegal, out_shift}, 2'b00);
        step();
        check("t1_popped", out_valid, 0);
        check("t1_err", err_cnt, 0);

        // backpressure with DEPTH=2
        out_ready = 0; in_valid = 1; in_aluop = 3'd1;
        step();
        in_aluop = 3'd2;
        step();
        in_aluop = 3'd3;
        check("t2_full_ready", in_ready, 0);
        check("t2_head", {out_ctrl, out_shift}, {5'b00011, 1'b1});
        step();
        check("t2_refused_head", out_ctrl, 5'b00011);
        check("t2_still_full", in_ready, 0);
        out_ready = 1;
        step();
        check("t2_pop2", {out_ctrl, out_shift}, {5'b00111, 1'b1});
        check("t2_ready_back", in_ready, 1);
        step();
        in_valid = 0;
        check("t2_third", {out_valid, out_ctrl, out_shift}, {1'b1, 5'b01111, 1'b1});
        step();
        check("t2_empty", out_valid, 0);

        // illegal ops
        in_valid = 1; in_aluop = 3'd7; in_funct = 6'd0;
        step();
        check("t3_ill_a", {out_valid, out_ctrl, out_illegal}, {1'b1, 5'b00000, 1'b1});
        in_aluop = 3'd5; in_funct = 6'd3;
        step();
        check("t3_ill_b", {out_valid, out_ctrl, out_illegal}, {1'b1, 5'b00000, 1'b1});
        in_aluop = 3'd7; in_funct = 6'd9;
        step();
        in_valid = 0;
        check("t3_ill_c", {out_valid, out_ctrl, out_illegal}, {1'b1, 5'b00000, 1'b1});
        check("t3_err_cnt", err_cnt, 3);
        step();

        // clear alone
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        check("t3_clr", err_cnt, 0);

        // 2-bit counter saturation, then clear with concurrent illegal push
        in2_valid = 1; in2_aluop = 3'd6; out2_ready = 1;
        for (int i = 0; i < 5; i++) step();
        check("t4_sat", err2_cnt, 3);
        cnt2_clr = 1;
        step();
        check("t4_clr_push", err2_cnt, 1);
        in2_valid = 0;
        step();
        check("t4_clr_alone", err2_cnt, 0);
        cnt2_clr = 0;

        // streaming 200 random ops, one per cycle
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 200; i++) begin
            in_aluop = 3'($urandom_range(0, 7));
            in_funct = 6'($urandom_range(0, 15));
            check("t5_ready", in_ready, 1);
            exp_q.push_back(model(in_aluop, in_funct));
            step();
            exp_v = exp_q.pop_front();
            check("t5_head", {out_valid, out_ctrl, out_illegal, out_shift}, {1'b1, exp_v});
        end
        in_valid = 0;
        step();
        check("t5_drained", out_valid, 0);

        // reset mid-stream with two entries buffered
        out_ready = 0; in_valid = 1; in_aluop = 3'd1;
        step();
        in_aluop = 3'd3;
        step();
        in_valid = 0;
        check("t6_buffered", {out_valid, in_ready}, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ready", in_ready, 1);
        check("t6_rst_ctrl", {out_ctrl, out_illegal, out_shift}, 7'd0);
        #1;
        rst = 1'b1;
        step();
        in_valid = 1; in_aluop = 3'd4; in_funct = 6'd2; out_ready = 1;
        step();
        in_valid = 0;
        check("t6_first_new", {out_valid, out_ctrl, out_illegal, out_shift}, {1'b1, 5'b01100, 2'b00});
        step();
        check("t6_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
Parametrised, registered successor to the combinational ALU control decoder. It accepts {ALUop, funct} pairs over a valid/ready handshake, decodes each to an ALU control word plus illegal/shift flags, and buffers the results in a DEPTH-entry FIFO. A saturating counter records illegal operations for debug. The block sits between the instruction-decode stage and the ALU in the pipelined datapath.

Parameters:
OP_W, 3, ALUop width
FUNCT_W, 6, funct field width
CTRL_W, 5, ALU control word width (must be >= 5)
DEPTH, 2, output FIFO entries; power of 2, >= 2
ERR_CNT_W, 8, illegal-op counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream presents an op
in_ready  out  1  block can accept an op
in_aluop  in  OP_W  ALUop
in_funct  in  FUNCT_W  funct field
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_ctrl  out  CTRL_W  decoded ALU control word
out_illegal  out  1  head op was undefined
out_shift  out  1  head op is a shift (ctrl 00011/00111/01111)
err_cnt  out  ERR_CNT_W  accepted illegal ops, saturating
cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Decode (combinational, zero-extended to CTRL_W):
  - ALUop 000 -> 00000
  - ALUop 001 -> 00011 (sll)
  - ALUop 010 -> 00111 (srl)
  - ALUop 011 -> 01111 (sra)
  - ALUop 100 -> 01100 (comp imm)
  - ALUop 111 with funct 1..8 -> 00000, 01100, 00001, 00010, 10000, 00011, 00111, 01111 respectively
  - ALUop 111 with any other funct, or ALUop 101/110 -> ctrl 00000, illegal=1
  - ALUop 000-100 ignore funct entirely.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = !full. It is registered-state derived only, with no combinational path from out_ready. A push is therefore refused when the FIFO is full, even if a pop happens in the same cycle.
- out_valid = !empty. out_ctrl, out_illegal and out_shift show the head entry; they hold 0 when empty.
- Latency: an op pushed at edge N appears on the outputs after edge N (1 cycle) when the FIFO was empty.
- Pushes and pops are simultaneous when not full and not empty: occupancy is unchanged and ordering is strict FIFO.
- Read and write pointers wrap modulo DEPTH. Occupancy is tracked with a counter of width clog2(DEPTH)+1.
- err_cnt increments on each push with illegal=1 and saturates at all-ones.
  - cnt_clr alone -> 0.
  - cnt_clr together with an illegal push -> 1 (the event is not lost).
- Reset (async assert, sync release):
  - FIFO empty, pointers 0, err_cnt 0.
  - out_valid 0, out_ctrl/out_illegal/out_shift 0, in_ready 1.
  - Reset mid-stream discards all buffered entries; no partial pop is visible.
- Inputs are don't-care when in_valid=0. Unused ctrl bits above bit 4 are always 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUop codes (OP_NONE, OP_SLL, OP_SRL, OP_SRA, OP_COMPI, OP_RTYPE)
  - funct codes (F_ADD .. F_SHRAV)
  - ctrl encodings (CTRL_ADD=00000, CTRL_AND=00001, CTRL_XOR=00010, CTRL_SLL=00011, CTRL_SRL=00111, CTRL_SRA=01111, CTRL_COMP=01100, CTRL_DIFF=10000)
- One sub-module, alu_ctrl_decode: purely combinational, producing {ctrl, illegal, shift} from {aluop, funct}. alu_ctrl_pipe instantiates it and owns the FIFO and counter.

Test Plan:
- Reset, then push ALUop=111/funct=5 with out_ready=1 -> one cycle later out_valid=1, out_ctrl=10000, illegal=0, shift=0; popped next edge; err_cnt=0.
- Hold out_ready=0 and push 001, 010, 011 (DEPTH=2) -> third push refused (in_ready=0 after two pushes). Then raise out_ready -> pops 00011 then 00111, shift=1 on both; 011 is accepted once in_ready returns.
- Push ALUop=111/funct=0, ALUop=101, and ALUop=111/funct=9 -> each pops ctrl=00000 with illegal=1; err_cnt=3.
- ERR_CNT_W=2: push 5 illegal ops -> err_cnt saturates at 3. Then cnt_clr together with an illegal push -> err_cnt=1.
- Continuous in_valid/out_ready=1 with a random stream of 200 ops -> outputs match the alu_ctrl_decode model in order, one op per cycle, no drops.
- Assert rst low mid-stream with 2 entries buffered -> immediately out_valid=0 and in_ready=1; after release the first new push is the first op seen at the output.
